// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the LegV8 fetch/PC stage.
package fetch_pkg;

   localparam int unsigned XLEN        = 64;
   localparam int unsigned ILEN        = 32;
   localparam int unsigned INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      PS_HOLD = 2'b00,
      PS_INC  = 2'b01,
      PS_REG  = 2'b10,
      PS_REL  = 2'b11
   } ps_e;

   typedef enum logic [1:0] {
      ST_FETCH = 2'b00,
      ST_LOAD  = 2'b01,
      ST_EXEC  = 2'b10,
      ST_EXEC2 = 2'b11
   } state_e;

   // Word offset to byte offset; the top two bits of k fall off.
   function automatic logic [XLEN-1:0] word_to_byte(input logic [XLEN-1:0] words);
      return words << 2;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Synchronous instruction-memory port between the fetch stage and imem.
interface fetch_unit_if;
   import fetch_pkg::*;

   logic            imem_ren;
   logic [XLEN-1:0] imem_addr;
   logic [ILEN-1:0] imem_rdata;

   modport master (output imem_ren, output imem_addr, input imem_rdata);
   modport slave  (input imem_ren, input imem_addr, output imem_rdata);

endinterface

// File: rtl/fetch_unit_next_pc_mux.sv
// Combinational next-PC selection; the alignment error only exists when
// FETCH_ALIGN_CHECK_EN is defined, otherwise BR low bits are cleared silently.
module next_pc_mux
   import fetch_pkg::*;
(
   input  logic [1:0]      ps,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] k,
   output logic [XLEN-1:0] next_pc,
   output logic            align_err
);

   always_comb begin
      next_pc   = pc;
      align_err = 1'b0;
      case (ps_e'(ps))
         PS_HOLD: next_pc = pc;
         PS_INC:  next_pc = pc + XLEN'(INSTR_BYTES);
         PS_REG: begin
            next_pc = branch_target & ~XLEN'(INSTR_BYTES - 1);
`ifdef FETCH_ALIGN_CHECK_EN
            align_err = |branch_target[1:0];
`endif
         end
         PS_REL:  next_pc = pc + word_to_byte(k);
         default: next_pc = pc;
      endcase
   end

endmodule

// File: rtl/fetch_unit.sv
// LegV8 instruction fetch / PC stage: FETCH -> LOAD -> EXEC [-> EXEC2] -> FETCH.
// Optional misaligned-BR trap enabled by FETCH_ALIGN_CHECK_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic [1:0]        ps,
   input  logic              cw_state,
   input  logic [XLEN-1:0]   branch_target,
   input  logic [XLEN-1:0]   k,
   input  logic              stall,
   fetch_unit_if.master      imem,
   output logic [ILEN-1:0]   instr,
   output logic              instr_valid,
   output logic [XLEN-1:0]   pc,
   output logic [XLEN-1:0]   pc_plus4,
   output logic              misalign
);

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [ILEN-1:0] instr_q, instr_d;
   logic            instr_valid_q, instr_valid_d;
   logic            imem_ren_q, imem_ren_d;
   logic [XLEN-1:0] next_pc;
   logic            align_err;
   logic            retire;

`ifdef FETCH_ALIGN_CHECK_EN
   logic            misalign_q, misalign_d;
`endif

   next_pc_mux u_next_pc_mux (
      .ps            (ps),
      .pc            (pc_q),
      .branch_target (branch_target),
      .k             (k),
      .next_pc       (next_pc),
      .align_err     (align_err)
   );

   // Next state; a FETCH entered from reset waits one cycle to issue its read.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      retire  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_d = misalign_q;
`endif
      case (state_q)
         ST_FETCH: if (imem_ren_q) state_d = ST_LOAD;
         ST_LOAD: begin
            instr_d = imem.imem_rdata;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (!stall) begin
               if (cw_state) state_d = ST_EXEC2;
               else          retire  = 1'b1;
            end
         end
         ST_EXEC2: if (!stall) retire = 1'b1;
         default:  state_d = ST_FETCH;
      endcase

      if (retire) begin
         state_d = ST_FETCH;
         if (!align_err) pc_d = next_pc;
`ifdef FETCH_ALIGN_CHECK_EN
         misalign_d = misalign_q | align_err;
`endif
      end

      imem_ren_d    = (state_d == ST_FETCH);
      instr_valid_d = (state_d == ST_EXEC) || (state_d == ST_EXEC2);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_FETCH;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         imem_ren_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         imem_ren_q    <= imem_ren_d;
      end
   end

`ifdef FETCH_ALIGN_CHECK_EN
   always_ff @(posedge clock) begin
      if (reset) misalign_q <= 1'b0;
      else       misalign_q <= misalign_d;
   end
   assign misalign = misalign_q;
`else
   assign misalign = 1'b0;
`endif

   assign imem.imem_ren  = imem_ren_q;
   assign imem.imem_addr = pc_q;
   assign instr          = instr_q;
   assign instr_valid    = instr_valid_q;
   assign pc             = pc_q;
   assign pc_plus4       = pc_q + XLEN'(INSTR_BYTES);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a one-cycle-latency imem model.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [1:0]  ps;
   logic        cw_state;
   logic [63:0] branch_target;
   logic [63:0] k;
   logic        stall;
   logic [31:0] instr;
   logic        instr_valid;
   logic [63:0] pc;
   logic [63:0] pc_plus4;
   logic        misalign;

   int total = 0;
   int bad   = 0;

   fetch_unit_if ifc ();

   fetch_unit #(.RESET_PC(64'h0)) dut (
      .clock         (clock),
      .reset         (reset),
      .ps            (ps),
      .cw_state      (cw_state),
      .branch_target (branch_target),
      .k             (k),
      .stall         (stall),
      .imem          (ifc),
      .instr         (instr),
      .instr_valid   (instr_valid),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .misalign      (misalign)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [63:0] addr);
      case (addr)
         64'h0:   return 32'h8B02_0020;
         64'h4:   return 32'hD61F_0020;
         default: return addr[31:0] ^ 32'hDEAD_BEEF;
      endcase
   endfunction

   always @(posedge clock)
      if (ifc.imem_ren) ifc.imem_rdata <= mem_word(ifc.imem_addr);

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         @(negedge clock);
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; ps = 2'b01; cw_state = 1'b0; stall = 1'b0;
      branch_target = 64'h0; k = 64'h0;
      tick(2);
      chk("rst_pc", pc, 64'h0);
      chk("rst_valid", 64'(instr_valid), 64'h0);
      chk("rst_ren", 64'(ifc.imem_ren), 64'h0);
      chk("rst_instr", 64'(instr), 64'h0);
      chk("rst_misalign", 64'(misalign), 64'h0);

      // First fetch after reset, sequential instruction at 0
      reset = 1'b0;
      tick(1);
      chk("f0_ren", 64'(ifc.imem_ren), 64'h1);
      chk("f0_addr", ifc.imem_addr, 64'h0);
      chk("f0_valid", 64'(instr_valid), 64'h0);
      tick(1);
      chk("l0_ren", 64'(ifc.imem_ren), 64'h0);
      chk("l0_valid", 64'(instr_valid), 64'h0);
      tick(1);
      chk("e0_instr", 64'(instr), 64'h8B02_0020);
      chk("e0_valid", 64'(instr_valid), 64'h1);
      chk("e0_pc4", pc_plus4, 64'h4);
      tick(1);
      chk("f1_ren", 64'(ifc.imem_ren), 64'h1);
      chk("f1_addr", ifc.imem_addr, 64'h4);
      chk("f1_valid", 64'(instr_valid), 64'h0);

      // BR to 0x100
      tick(2);
      chk("e1_instr", 64'(instr), 64'hD61F_0020);
      chk("e1_pc4", pc_plus4, 64'h8);
      ps = 2'b10; branch_target = 64'h100;
      tick(1);
      chk("br_addr", ifc.imem_addr, 64'h100);
      chk("br_ren", 64'(ifc.imem_ren), 64'h1);
      tick(2);
      chk("br_instr", 64'(instr), 64'hDEAD_BFEF);

      // BR to 0x40, then B with k=-2
      branch_target = 64'h40;
      tick(3);
      chk("e40_pc", pc, 64'h40);
      ps = 2'b11; k = 64'hFFFF_FFFF_FFFF_FFFE;
      tick(1);
      chk("rel_back", pc, 64'h38);

      // BR to 0, then B with k=-1 wraps
      tick(2);
      ps = 2'b10; branch_target = 64'h0;
      tick(1);
      chk("br_zero", pc, 64'h0);
      tick(2);
      ps = 2'b11; k = 64'hFFFF_FFFF_FFFF_FFFF;
      tick(1);
      chk("rel_wrap", pc, 64'hFFFF_FFFF_FFFF_FFFC);

      // k top bits dropped by the shift; sum wraps to 0
      tick(2);
      k = 64'h4000_0000_0000_0001;
      tick(1);
      chk("rel_drop", pc, 64'h0);

      // Hold
      tick(2);
      ps = 2'b00;
      tick(1);
      chk("hold_pc", pc, 64'h0);
      chk("hold_addr", ifc.imem_addr, 64'h0);

      // Stall in EXEC, then two-cycle instruction stalled 2 cycles in EXEC2
      tick(2);
      ps = 2'b01; stall = 1'b1;
      tick(1);
      chk("st_e_valid", 64'(instr_valid), 64'h1);
      chk("st_e_pc", pc, 64'h0);
      stall = 1'b0; cw_state = 1'b1;
      tick(1);
      chk("e2_valid", 64'(instr_valid), 64'h1);
      chk("e2_pc", pc, 64'h0);
      chk("e2_instr", 64'(instr), 64'h8B02_0020);
      stall = 1'b1; cw_state = 1'b0; ps = 2'b00;
      tick(2);
      chk("e2s_valid", 64'(instr_valid), 64'h1);
      chk("e2s_pc", pc, 64'h0);
      chk("e2s_instr", 64'(instr), 64'h8B02_0020);
      stall = 1'b0; ps = 2'b11; k = 64'h3;
      tick(1);
      chk("e2_leave_pc", pc, 64'hC);
      chk("e2_leave_valid", 64'(instr_valid), 64'h0);
      chk("e2_leave_ren", 64'(ifc.imem_ren), 64'h1);

      // Misaligned BR target
      tick(2);
      ps = 2'b10; branch_target = 64'h102;
      tick(1);
`ifdef FETCH_ALIGN_CHECK_EN
      chk("mis_pc", pc, 64'hC);
      chk("mis_flag", 64'(misalign), 64'h1);
`else
      chk("mis_pc", pc, 64'h100);
      chk("mis_flag", 64'(misalign), 64'h0);
`endif
      chk("mis_ren", 64'(ifc.imem_ren), 64'h1);

      // Reset in EXEC2 with a pending update and stall high
      tick(2);
      ps = 2'b01; cw_state = 1'b1;
      tick(1);
      chk("pre_rst_valid", 64'(instr_valid), 64'h1);
      reset = 1'b1; stall = 1'b1;
      tick(1);
      chk("mrst_pc", pc, 64'h0);
      chk("mrst_misalign", 64'(misalign), 64'h0);
      chk("mrst_valid", 64'(instr_valid), 64'h0);
      chk("mrst_ren", 64'(ifc.imem_ren), 64'h0);
      reset = 1'b0; stall = 1'b0; cw_state = 1'b0;
      tick(1);
      chk("mrst_fetch_ren", 64'(ifc.imem_ren), 64'h1);
      chk("mrst_fetch_addr", ifc.imem_addr, 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
